relu_maxpool1d: RTL and testbench
=================================

// Module: relu_maxpool1d
// PURPOSE
//  Downstream stage of the 64-channel batch-norm layer in the PPG->CO network.
//  Accepts one normalised 64-sample vector and applies ReLU (optional upper cap).
//  Max-pools by POOL, computing LANES windows per cycle, and emits a 32-sample vector.
//  Uses a valid/ready handshake in both directions; it feeds the next conv1d stage.
// PARAMETERS
//  N_IN      64   input vector length; N_IN % (POOL*LANES) must be 0 (elaboration $error)
//  DATA_W    16   signed sample width, two's complement
//  POOL      2    pooling window size (stride == POOL, no overlap)
//  LANES     4    pooled outputs computed per RUN cycle
//  RELU_CAP  0    0: plain ReLU; >0: output clamped to [0, RELU_CAP]
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              synchronous, active-low (0 = reset)
//  valid_in     in   1              input vector valid
//  ready_out    out  1              block can accept a vector
//  input_data   in   DATA_W x N_IN  signed samples [0:N_IN-1]
//  output_data  out  DATA_W x N_OUT signed pooled samples, N_OUT = N_IN/POOL
//  valid_out    out  1              output_data complete and stable
//  ready_in     in   1              downstream accepts the output vector
// BEHAVIOUR
//  Reset (reset==0 at an edge)
//  - state=IDLE, idx=0, ready_out=1, valid_out=0.
//  - All output_data and the capture buffer are set to 0.
//  - Reset overrides every other input, including mid-RUN and mid-DONE.
//  FSM: IDLE -> RUN -> DONE -> IDLE
//  - IDLE: ready_out=1. On an edge with valid_in&ready_out, latch input_data into
//    buf, set idx=0, go to RUN.
//  - RUN: ready_out=0. Each cycle, for lane l in 0..LANES-1 with o = idx+l:
//    out[o] = relu(max(buf[o*POOL .. o*POOL+POOL-1])), then idx += LANES.
//    On the cycle with idx == N_OUT-LANES, go to DONE.
//  - DONE: valid_out=1 and output_data held stable. On an edge with ready_in=1,
//    go to IDLE; valid_out drops on that edge.
//  Latency and throughput
//  - valid_out rises N_OUT/LANES edges after the accept edge (8 with defaults).
//  - Throughput is one vector per N_OUT/LANES+2 cycles.
//  - ready_out is 0 in RUN and DONE; valid_in there is ignored (no capture).
//  Arithmetic
//  - max is a signed compare. relu(x) = x<0 ? 0 : x.
//  - With RELU_CAP>0, results > RELU_CAP become RELU_CAP.
//  - No growth or overflow; output width stays DATA_W.
//  - -32768 maps to 0. Ties are value-equal, so no lane ordering is needed.
//  Other rules
//  - input_data may change after the accept edge; only buf is used.
//  - output_data bits not yet written during RUN keep the previous vector's values.
//  - valid_in & ready_in both 1 in DONE: only the DONE->IDLE exit happens. The new
//    vector is accepted on a later edge in IDLE.
// STRUCTURE
//  Shared package cnn_pkg:
//  - DATA_W, typedef logic signed [DATA_W-1:0] sample_t.
//  - typedef enum {IDLE,RUN,DONE} pool_state_t.
//  - function relu_clamp(sample_t, cap).
//  Sub-module relu_max_lane: combinational POOL-input signed max plus ReLU/cap.
//  - Instantiated LANES times (generate).
//  The top module holds the FSM, idx counter, buf and output registers.
// TESTING
//  1. Basic pairs. Input [302,-256,-56,268,278,-34,219,316,-298,-7,...]
//     -> out[0..4] = 302,268,278,316,0; valid_out 8 cycles after accept.
//  2. Negative/extreme values. All inputs negative, with pair (-32768,-1)
//     -> all 32 outputs 0.
//  3. Cap. RELU_CAP=255, pair (395,-3) -> 255; pair (142,-283) -> 142.
//  4. Backpressure. Hold ready_in=0 for 20 cycles in DONE
//     -> valid_out stays 1, ready_out stays 0, output_data unchanged.
//     Then ready_in=1 -> IDLE next cycle with ready_out=1.
//  5. Reset mid-RUN. reset=0 on the 4th RUN cycle -> next edge: IDLE,
//     valid_out=0, output_data all 0. The following vector is processed correctly.
//  6. Back-to-back. valid_in held high with ready_in=1 -> consecutive vectors
//     accepted every 10 cycles; each result matches a software reference model.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_pkg
//  Brief    : Shared types and ReLU/cap helper for the PPG->CO CNN datapath.
//  Revision : 1.0  initial release
// ============================================================================
package cnn_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_t;

    // cap <= 0 selects plain ReLU; otherwise results are clamped to [0, cap].
    function automatic sample_t relu_clamp(input sample_t x, input int cap);
        sample_t r;
        r = x;
        if (x < 0)
            r = '0;
        else if ((cap > 0) && (int'(x) > cap))
            r = sample_t'(cap);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_max_lane.sv
`default_nettype none
// ============================================================================
//  Module   : relu_max_lane
//  Brief    : Combinational POOL-input signed max followed by ReLU / cap.
//  Revision : 1.0  initial release
// ============================================================================
module relu_max_lane
    import cnn_pkg::*;
#(
    parameter int POOL     = 2,
    parameter int RELU_CAP = 0
) (
    input  sample_t [POOL-1:0] win,
    output sample_t            y
);

    sample_t max_v;

    always_comb begin
        max_v = win[0];
        for (int i = 1; i < POOL; i++) begin
            if (win[i] > max_v)
                max_v = win[i];
        end
    end

    assign y = relu_clamp(max_v, RELU_CAP);

endmodule
`default_nettype wire

// File: rtl/relu_maxpool1d.sv
`default_nettype none
// ============================================================================
//  Module   : relu_maxpool1d
//  Brief    : ReLU + 1-D max-pool over one captured vector, LANES windows/cycle.
//  Revision : 1.0  initial release
// ============================================================================
module relu_maxpool1d #(
    parameter int N_IN     = 64,
    parameter int DATA_W   = cnn_pkg::DATA_W,
    parameter int POOL     = 2,
    parameter int LANES    = 4,
    parameter int RELU_CAP = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  valid_in,
    output logic                                  ready_out,
    input  logic [N_IN-1:0][DATA_W-1:0]           input_data,
    output logic [(N_IN/POOL)-1:0][DATA_W-1:0]    output_data,
    output logic                                  valid_out,
    input  logic                                  ready_in
);

    import cnn_pkg::*;

    localparam int N_OUT = N_IN / POOL;
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - LANES);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

    if ((N_IN % (POOL * LANES)) != 0) begin : g_bad_geometry
        $error("relu_maxpool1d: N_IN must be a multiple of POOL*LANES");
    end
    if (DATA_W != cnn_pkg::DATA_W) begin : g_bad_width
        $error("relu_maxpool1d: DATA_W must match cnn_pkg::DATA_W");
    end

    pool_state_t      state;
    logic [IDX_W-1:0] idx;
    sample_t          cap_buf [N_IN];
    sample_t          lane_y  [LANES];

    // Lane l pools output index idx+l from the captured copy, never from input_data.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sample_t [POOL-1:0] win;

        always_comb begin
            win = '0;
            for (int p = 0; p < POOL; p++)
                win[p] = cap_buf[SEL_W'((int'(idx) + l) * POOL + p)];
        end

        relu_max_lane #(
            .POOL     (POOL),
            .RELU_CAP (RELU_CAP)
        ) u_lane (
            .win (win),
            .y   (lane_y[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            ready_out   <= 1'b1;
            valid_out   <= 1'b0;
            output_data <= '0;
            for (int i = 0; i < N_IN; i++)
                cap_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in && ready_out) begin
                        for (int i = 0; i < N_IN; i++)
                            cap_buf[i] <= sample_t'(input_data[i]);
                        idx       <= '0;
                        ready_out <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++)
                        output_data[idx + IDX_W'(l)] <= lane_y[l];
                    idx <= idx + IDX_STEP;
                    if (idx == IDX_LAST) begin
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // A pending valid_in is deliberately not taken here; IDLE accepts it next.
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        ready_out <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool1d.sv
`default_nettype none
// ============================================================================
//  Module   : tb_relu_maxpool1d
//  Brief    : Scoreboard bench for relu_maxpool1d (plain and capped instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_relu_maxpool1d;

    localparam int N_IN  = 64;
    localparam int N_OUT = 32;
    localparam int DW    = 16;

    typedef logic [N_IN-1:0][DW-1:0]  ivec_t;
    typedef logic [N_OUT-1:0][DW-1:0] ovec_t;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    logic  reset;
    logic  valid_in, ready_out, valid_out, ready_in;
    ivec_t input_data;
    ovec_t output_data;

    logic  c_valid_in, c_ready_out, c_valid_out;
    logic  c_ready_in = 1'b1;
    ivec_t c_input_data;
    ovec_t c_output_data;

    int    passed = 0;
    int    total  = 0;
    int    cyc    = 0;
    ovec_t q_main[$];
    ovec_t q_cap[$];

    ivec_t v;
    ovec_t e;
    int    k;
    int    acc[3];
    bit    hold_ok_v, hold_ok_r;

    relu_maxpool1d #(.N_IN(N_IN), .DATA_W(DW), .POOL(2), .LANES(4), .RELU_CAP(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .input_data  (input_data),
        .output_data (output_data),
        .valid_out   (valid_out),
        .ready_in    (ready_in)
    );

    relu_maxpool1d #(.N_IN(N_IN), .DATA_W(DW), .POOL(2), .LANES(4), .RELU_CAP(255)) dut_cap (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (c_valid_in),
        .ready_out   (c_ready_out),
        .input_data  (c_input_data),
        .output_data (c_output_data),
        .valid_out   (c_valid_out),
        .ready_in    (c_ready_in)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endfunction

    function automatic void cmp_vec(input string name, input ovec_t got, input ovec_t exp);
        int bad;
        bad = -1;
        for (int o = N_OUT - 1; o >= 0; o--)
            if (got[o] !== exp[o]) bad = o;
        total++;
        if (bad < 0) passed++;
        else $display("FAIL %s: out[%0d] got %0d expected %0d", name, bad,
                      $signed(got[bad]), $signed(exp[bad]));
    endfunction

    // Reference: pairwise signed max, ReLU, optional cap.
    function automatic ovec_t model(input ivec_t vi, input int cap);
        ovec_t r;
        int a, b, m;
        for (int o = 0; o < N_OUT; o++) begin
            a = int'($signed(vi[2*o]));
            b = int'($signed(vi[2*o+1]));
            m = (a > b) ? a : b;
            if (m < 0) m = 0;
            if (cap > 0 && m > cap) m = cap;
            r[o] = DW'(m);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset && valid_out && ready_in) begin
            if (q_main.size() == 0) begin
                total++;
                $display("FAIL main_unexpected: got an output vector, expected none");
            end else cmp_vec("main_out", output_data, q_main.pop_front());
        end
        if (reset && c_valid_out && c_ready_in) begin
            if (q_cap.size() == 0) begin
                total++;
                $display("FAIL cap_unexpected: got an output vector, expected none");
            end else cmp_vec("cap_out", c_output_data, q_cap.pop_front());
        end
    end

    task automatic send(input ivec_t vi, input ovec_t exp, input bit do_push);
        int n;
        input_data = vi;
        valid_in   = 1'b1;
        n = 0;
        while (!ready_out && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_out) begin
            chk("accept_timeout", 0, 1);
            valid_in = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (do_push) q_main.push_back(exp);
        valid_in = 1'b0;
        for (int i = 0; i < N_IN; i++) input_data[i] = DW'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_out && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!valid_out) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; valid_in = 1'b0; ready_in = 1'b1; input_data = '0;
        c_valid_in = 1'b0; c_input_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_out", ready_out, 1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_output_zero", (output_data == '0), 1);
        reset = 1'b1;

        // 1: basic pairs, latency
        v = '0;
        v[0] = 302; v[1] = -256; v[2] = -56; v[3] = 268; v[4] = 278;
        v[5] = -34; v[6] = 219;  v[7] = 316; v[8] = -298; v[9] = -7;
        for (int i = 10; i < N_IN; i++) v[i] = DW'(((i * 37) % 200) - 100);
        e = model(v, 0);
        e[0] = 302; e[1] = 268; e[2] = 278; e[3] = 316; e[4] = 0;
        send(v, e, 1);
        wait_valid(k);
        chk("latency", k, 8);
        repeat (2) @(posedge clk);
        #1;

        // 2: all negative, including the most negative value
        for (int i = 0; i < N_IN; i++) v[i] = DW'(-1 - i * 100);
        v[0] = 16'h8000; v[1] = -1;
        send(v, '0, 1);
        wait_valid(k);
        repeat (2) @(posedge clk);
        #1;

        // 3: capped instance
        for (int i = 0; i < N_IN; i++) v[i] = DW'((i % 3 == 0) ? -500 : 1000 - i * 10);
        v[0] = 395; v[1] = -3; v[2] = 142; v[3] = -283;
        e = model(v, 255);
        e[0] = 255; e[1] = 142;
        c_input_data = v;
        c_valid_in   = 1'b1;
        @(posedge clk); #1;
        q_cap.push_back(e);
        c_valid_in = 1'b0;
        k = 0;
        while (!c_valid_out && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("cap_latency", k, 8);
        repeat (2) @(posedge clk);
        #1;

        // 4: backpressure
        ready_in = 1'b0;
        for (int i = 0; i < N_IN; i++) v[i] = DW'(((i * 53) % 301) - 150);
        e = model(v, 0);
        send(v, e, 1);
        wait_valid(k);
        hold_ok_v = 1'b1; hold_ok_r = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!valid_out) hold_ok_v = 1'b0;
            if (ready_out)  hold_ok_r = 1'b0;
        end
        chk("bp_valid_held", hold_ok_v, 1);
        chk("bp_ready_low", hold_ok_r, 1);
        cmp_vec("bp_data_stable", output_data, e);
        ready_in = 1'b1;
        @(posedge clk); #1;
        chk("bp_exit_ready_out", ready_out, 1);
        chk("bp_exit_valid_out", valid_out, 0);

        // 5: reset during the 4th RUN cycle
        for (int i = 0; i < N_IN; i++) v[i] = DW'(i * 7);
        send(v, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrun_ready_out", ready_out, 1);
        chk("midrun_valid_out", valid_out, 0);
        chk("midrun_output_zero", (output_data == '0), 1);
        reset = 1'b1;
        for (int i = 0; i < N_IN; i++) v[i] = DW'(500 - i * 13);
        send(v, model(v, 0), 1);
        wait_valid(k);
        chk("post_reset_latency", k, 8);
        repeat (2) @(posedge clk);
        #1;

        // 6: back-to-back with valid_in held high
        ready_in = 1'b1;
        valid_in = 1'b1;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < N_IN; i++) v[i] = DW'(((i * (n + 3) * 29) % 1001) - 500);
            input_data = v;
            k = 0;
            while (!ready_out && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            @(posedge clk); #1;
            acc[n] = cyc;
            q_main.push_back(model(v, 0));
        end
        valid_in = 1'b0;
        chk("b2b_interval_1", acc[1] - acc[0], 10);
        chk("b2b_interval_2", acc[2] - acc[1], 10);
        wait_valid(k);
        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", q_main.size() + q_cap.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
